// File: rtl/cpc_bus_cycle_tracker_pkg.sv
// Shared constants for the CPC bus cycle tracker: state encoding, cycle types,
// bank-select prefix and the bank-write decode helper.
package cpc_bus_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'b000;
    localparam state_t ST_M_ACT = 3'b001;
    localparam state_t ST_M_T3  = 3'b010;
    localparam state_t ST_I_ACT = 3'b011;
    localparam state_t ST_I_T3  = 3'b100;
    localparam state_t ST_END   = 3'b101;

    localparam logic CYC_RD = 1'b0;
    localparam logic CYC_WR = 1'b1;

    localparam logic [1:0] BANK_PREFIX_DFLT = 2'b11;

    // Bank-select writes go to an I/O port with A15 low and carry the prefix in data[7:6].
    function automatic logic is_bank_write(input logic adr15, input logic [1:0] data_hi,
                                           input logic [1:0] prefix);
        return (adr15 == 1'b0) && (data_hi == prefix);
    endfunction

endpackage

// File: rtl/cpc_bus_cycle_tracker_if.sv
// Raw Z80/CPC bus strobes in, clean cycle qualifiers and bank register out.
// master = bus/stimulus side, slave = the tracker.
interface cpc_bus_cycle_tracker_if #(
    parameter int WAIT_CNT_W = 3
);
    logic                  mreq_b;
    logic                  iorq_b;
    logic                  rd_b;
    logic                  wr_b;
    logic                  m1_b;
    logic                  rfsh_b;
    logic                  ready;
    logic                  adr15;
    logic [7:0]            data;
    logic                  mrd_cyc;
    logic                  mwr_cyc;
    logic                  io_wr_stb;
    logic [7:0]            io_wr_data;
    logic [5:0]            bank_q;
    logic                  bank_wr_stb;
    logic                  adr15_q;
    logic [WAIT_CNT_W-1:0] wait_cnt;

    modport master (
        output mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b, ready, adr15, data,
        input  mrd_cyc, mwr_cyc, io_wr_stb, io_wr_data, bank_q, bank_wr_stb, adr15_q, wait_cnt
    );

    modport slave (
        input  mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b, ready, adr15, data,
        output mrd_cyc, mwr_cyc, io_wr_stb, io_wr_data, bank_q, bank_wr_stb, adr15_q, wait_cnt
    );

endinterface

// File: rtl/cpc_bus_cycle_tracker_ready_sampler.sv
// Falling-edge sampler for CPC READY; resets to "ready" so no phantom wait
// states appear right after reset.
module cpc_ready_sampler (
    input  logic clk,
    input  logic reset_b,
    input  logic i_ready,
    output logic o_ready_f
);

    logic r_ready_f;

    // READY is sampled mid-T-state, on the falling clock edge
    always_ff @(negedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_ready_f <= 1'b1;
        end else begin
            r_ready_f <= i_ready;
        end
    end

    assign o_ready_f = r_ready_f;

endmodule

// File: rtl/cpc_bus_cycle_tracker.sv
// Z80/CPC bus cycle tracker: classifies machine cycles, strobes I/O writes and holds the RAM bank register.
// Build option MWR_HOLD_EN keeps mwr_cyc asserted through the END clock following a memory write.
module cpc_bus_cycle_tracker
    import cpc_bus_pkg::*;
#(
    parameter logic [1:0] BANK_PREFIX = BANK_PREFIX_DFLT,
    parameter int         WAIT_CNT_W  = 3
) (
    input  logic                   clk,
    input  logic                   reset_b,
    cpc_bus_cycle_tracker_if.slave bus
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_MAX = {WAIT_CNT_W{1'b1}};
    localparam logic [WAIT_CNT_W-1:0] WAIT_ONE = WAIT_CNT_W'(1);

    logic                  r_mreq_q;
    logic                  r_iorq_q;
    logic                  w_ready_f;
    logic                  w_mem_start;
    logic                  w_io_start;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_cyc_type;
    logic                  w_cyc_type_nxt;

    logic                  w_mrd_nxt;
    logic                  w_mwr_nxt;
    logic                  w_io_wr_acc;
    logic                  w_bank_hit;
    logic                  w_mem_entry;
    logic                  w_wait_clr;
    logic                  w_wait_inc;

    logic                  r_mrd_cyc;
    logic                  r_mwr_cyc;
    logic                  r_io_wr_stb;
    logic                  r_bank_wr_stb;
    logic                  r_adr15_q;
    logic [7:0]            r_io_wr_data;
    logic [5:0]            r_bank_q;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;

    // Previous-clock copies of MREQ*/IORQ* for falling-edge detection
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_mreq_q <= 1'b1;
            r_iorq_q <= 1'b1;
        end else begin
            r_mreq_q <= bus.mreq_b;
            r_iorq_q <= bus.iorq_b;
        end
    end

    cpc_ready_sampler u_ready_sampler (
        .clk       (clk),
        .reset_b   (reset_b),
        .i_ready   (bus.ready),
        .o_ready_f (w_ready_f)
    );

    // Refresh and interrupt-acknowledge never open a tracked cycle
    assign w_mem_start = !bus.mreq_b && r_mreq_q && bus.rfsh_b;
    assign w_io_start  = !bus.iorq_b && r_iorq_q && bus.m1_b;

    // State and latched cycle-type register
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state    <= ST_IDLE;
            r_cyc_type <= CYC_RD;
        end else begin
            r_state    <= w_state_nxt;
            r_cyc_type <= w_cyc_type_nxt;
        end
    end

    // Next-state and cycle-type decision
    always_comb begin
        w_state_nxt    = r_state;
        w_cyc_type_nxt = r_cyc_type;
        case (r_state)
            ST_IDLE, ST_END: begin
                if (w_mem_start) begin
                    w_state_nxt    = ST_M_ACT;
                    w_cyc_type_nxt = bus.rd_b ? CYC_WR : CYC_RD;
                end else if (w_io_start) begin
                    w_state_nxt = ST_I_ACT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_M_ACT: begin
                if (bus.mreq_b) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    // RD* released and WR* low while MREQ* held: a late WR* fall
                    if ((r_cyc_type == CYC_RD) && bus.rd_b && !bus.wr_b) begin
                        w_cyc_type_nxt = CYC_WR;
                    end else begin
                        w_cyc_type_nxt = r_cyc_type;
                    end
                    w_state_nxt = w_ready_f ? ST_M_T3 : ST_M_ACT;
                end
            end
            ST_M_T3: w_state_nxt = ST_END;
            ST_I_ACT: begin
                if (bus.iorq_b) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = w_ready_f ? ST_I_T3 : ST_I_ACT;
                end
            end
            ST_I_T3: w_state_nxt = ST_END;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs
    always_comb begin
        w_mrd_nxt = 1'b0;
        w_mwr_nxt = 1'b0;
        if ((w_state_nxt == ST_M_ACT) || (w_state_nxt == ST_M_T3)) begin
            w_mrd_nxt = (w_cyc_type_nxt == CYC_RD);
            w_mwr_nxt = (w_cyc_type_nxt == CYC_WR);
        end else begin
            w_mrd_nxt = 1'b0;
`ifdef MWR_HOLD_EN
            w_mwr_nxt = (r_state == ST_M_T3) && (r_cyc_type == CYC_WR);
`else
            w_mwr_nxt = 1'b0;
`endif
        end

        w_io_wr_acc = (r_state == ST_I_ACT) && !bus.iorq_b && w_ready_f && !bus.wr_b;
        w_bank_hit  = w_io_wr_acc && is_bank_write(bus.adr15, bus.data[7:6], BANK_PREFIX);

        w_mem_entry = 1'b0;
        w_wait_clr  = 1'b0;
        if ((r_state == ST_IDLE) || (r_state == ST_END)) begin
            w_mem_entry = (w_state_nxt == ST_M_ACT);
            w_wait_clr  = (w_state_nxt == ST_M_ACT) || (w_state_nxt == ST_I_ACT);
        end else begin
            w_mem_entry = 1'b0;
            w_wait_clr  = 1'b0;
        end

        w_wait_inc = (((r_state == ST_M_ACT) && (w_state_nxt == ST_M_ACT)) ||
                      ((r_state == ST_I_ACT) && (w_state_nxt == ST_I_ACT))) &&
                     (r_wait_cnt != WAIT_MAX);
    end

    // Registered outputs, bank register and wait counter
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_mrd_cyc     <= 1'b0;
            r_mwr_cyc     <= 1'b0;
            r_io_wr_stb   <= 1'b0;
            r_bank_wr_stb <= 1'b0;
            r_adr15_q     <= 1'b0;
            r_io_wr_data  <= 8'h00;
            r_bank_q      <= 6'h00;
            r_wait_cnt    <= {WAIT_CNT_W{1'b0}};
        end else begin
            r_mrd_cyc     <= w_mrd_nxt;
            r_mwr_cyc     <= w_mwr_nxt;
            r_io_wr_stb   <= w_io_wr_acc;
            r_bank_wr_stb <= w_bank_hit;
            if (w_mem_entry) begin
                r_adr15_q <= bus.adr15;
            end
            if (w_io_wr_acc) begin
                r_io_wr_data <= bus.data;
            end
            if (w_bank_hit) begin
                r_bank_q <= bus.data[5:0];
            end
            if (w_wait_clr) begin
                r_wait_cnt <= {WAIT_CNT_W{1'b0}};
            end else if (w_wait_inc) begin
                r_wait_cnt <= r_wait_cnt + WAIT_ONE;
            end
        end
    end

    assign bus.mrd_cyc     = r_mrd_cyc;
    assign bus.mwr_cyc     = r_mwr_cyc;
    assign bus.io_wr_stb   = r_io_wr_stb;
    assign bus.io_wr_data  = r_io_wr_data;
    assign bus.bank_q      = r_bank_q;
    assign bus.bank_wr_stb = r_bank_wr_stb;
    assign bus.adr15_q     = r_adr15_q;
    assign bus.wait_cnt    = r_wait_cnt;

endmodule
